// File: rtl/router_output_if.sv
// Router output-stage bus: stage-2 flit/route/ack from upstream, flit push/credit exchange with downstream FQs.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 36
`endif

interface router_output_if #(
  parameter int unsigned NOUTPUTS = 10,
  parameter int unsigned FLIT_W   = `FLIT_WIDTH
);
  logic [FLIT_W-1:0]          s2_flit;
  logic                       s2_flit_valid;
  logic [NOUTPUTS-1:0]        s2_oport_decoded;
  logic                       s2_flit_routed;
  logic [NOUTPUTS*FLIT_W-1:0] flit_out;
  logic [NOUTPUTS-1:0]        flit_out_valid;
  logic [NOUTPUTS-1:0]        credit_in;
  logic [NOUTPUTS-1:0]        credit_avail;

  modport master (
    output s2_flit, s2_flit_valid, s2_oport_decoded, credit_in,
    input  s2_flit_routed, flit_out, flit_out_valid, credit_avail
  );

  modport slave (
    input  s2_flit, s2_flit_valid, s2_oport_decoded, credit_in,
    output s2_flit_routed, flit_out, flit_out_valid, credit_avail
  );
endinterface

// File: rtl/router_output.sv
// Router output stage: routes the stage-2 flit into one of NPORTS*NVCS downstream FQs under credit flow control.
// Optional ROUTER_OUTPUT_STATS_EN adds saturating sent-flit and stall-cycle counters.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 36
`endif

module router_output #(
  parameter int unsigned NPORTS    = 5,
  parameter int unsigned NVCS      = 2,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              sim_time_tick,
  router_output_if.slave    bus,
`ifdef ROUTER_OUTPUT_STATS_EN
  output logic [15:0]       stat_flits_sent,
  output logic [15:0]       stat_stall_cycles,
`endif
  output logic              error
);

  localparam int unsigned NOUTPUTS = NPORTS * NVCS;
  localparam int unsigned FW       = `FLIT_WIDTH;
  localparam int unsigned CW       = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] MAX_CREDITS = CW'(BUF_DEPTH);

  logic [CW-1:0]       cnt [NOUTPUTS];
  logic [NOUTPUTS-1:0] avail;
  logic [NOUTPUTS-1:0] full;
  logic [NOUTPUTS-1:0] dec;
  logic                onehot;
  logic                send;
  logic                dest_err;
  logic                credit_ovf;
  logic [FW-1:0]       flit_q;
  logic [NOUTPUTS-1:0] valid_q;

  // Accept decision and per-output credit bookkeeping
  always_comb begin
    avail = '0;
    full  = '0;
    for (int unsigned i = 0; i < NOUTPUTS; i++) begin
      avail[i] = (cnt[i] != '0);
      full[i]  = (cnt[i] == MAX_CREDITS);
    end
    onehot     = (bus.s2_oport_decoded != '0) &&
                 ((bus.s2_oport_decoded & (bus.s2_oport_decoded - NOUTPUTS'(1))) == '0);
    send       = enable & bus.s2_flit_valid & onehot & (|(bus.s2_oport_decoded & avail));
    dec        = send ? bus.s2_oport_decoded : '0;
    dest_err   = bus.s2_flit_valid & ~onehot;
    credit_ovf = |(bus.credit_in & ~dec & full);
  end

  assign bus.s2_flit_routed = send;
  assign bus.credit_avail   = avail;
  assign bus.flit_out       = {NOUTPUTS{flit_q}};
  assign bus.flit_out_valid = valid_q;

  // Credit counters: a credit returned at full depth saturates (and is flagged below)
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NOUTPUTS; i++) cnt[i] <= MAX_CREDITS;
    end else begin
      for (int unsigned i = 0; i < NOUTPUTS; i++) begin
        if (dec[i] && !bus.credit_in[i]) begin
          cnt[i] <= cnt[i] - CW'(1);
        end else if (!dec[i] && bus.credit_in[i] && !full[i]) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // One-cycle flit register; strobe lasts exactly one cycle per accepted flit
  always_ff @(posedge clock) begin
    if (reset) begin
      flit_q  <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= dec;
      if (send) flit_q <= bus.s2_flit;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) error <= 1'b0;
    else if (dest_err || credit_ovf) error <= 1'b1;
  end

`ifdef ROUTER_OUTPUT_STATS_EN
  logic stall;
  assign stall = enable & bus.s2_flit_valid & ~send;

  // Tick clears win over increments
  always_ff @(posedge clock) begin
    if (reset || sim_time_tick) begin
      stat_flits_sent   <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (send && stat_flits_sent != 16'hFFFF) stat_flits_sent <= stat_flits_sent + 16'd1;
      if (stall && stat_stall_cycles != 16'hFFFF) stat_stall_cycles <= stat_stall_cycles + 16'd1;
    end
  end
`else
  logic unused_tick;
  assign unused_tick = sim_time_tick;
`endif

endmodule
